// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - decoded-duty output bundle of pwm_capture
interface pwm_capture_if;
    logic [7:0]  duty;
    logic        dutyValid;
    logic        periodErr;
    logic [11:0] highTicks;

    modport master (output duty, output dutyValid, output periodErr, output highTicks);
    modport slave  (input  duty, input  dutyValid, input  periodErr, input  highTicks);
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM duty decoder with period check and constant-level timeout
// Optional glitch filter on the synchronized input: PWM_CAPTURE_FILTER_EN
module pwm_capture #(
    parameter int PRESCALE      = 50,
    parameter int PERIOD_TICKS  = 1024,
    parameter int TOL_TICKS     = 8,
    parameter int TIMEOUT_TICKS = 2048
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             pwmIn,
    pwm_capture_if.master    cap
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]       PRE_LAST = PW'(PRESCALE - 1);
    localparam logic signed [12:0]  PER13    = 13'(PERIOD_TICKS);
    localparam logic signed [12:0]  TOL13    = 13'(TOL_TICKS);
    localparam logic [11:0]         TO12     = 12'(TIMEOUT_TICKS);
    localparam logic [11:0]         CNT_MAX  = 12'hFFF;

    typedef enum logic [1:0] {IDLE, MEAS, TIMEOUT} state_t;

    state_t      state;
    logic        sync1, sync2, prev_level, level;
    logic [PW-1:0] pre;
    logic [11:0] hi_cnt, per_cnt, idle_cnt;
    logic [7:0]  duty_r;
    logic        valid_r, perr_r;
    logic [11:0] high_r;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwmIn;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    // Level follows the synchronizer only after three identical samples in a row.
    logic [1:0] hist;
    logic       filt;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hist <= 2'b00;
            filt <= 1'b0;
        end else begin
            hist <= {hist[0], sync2};
            if (sync2 == hist[0] && sync2 == hist[1])
                filt <= sync2;
        end
    end
    assign level = filt;
`else
    assign level = sync2;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_level <= 1'b0;
            pre        <= '0;
        end else begin
            prev_level <= level;
            pre        <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
        end
    end

    logic tick, rise, fall;
    assign tick = (pre == PRE_LAST);
    assign rise = level & ~prev_level;
    assign fall = ~level & prev_level;

    logic signed [12:0] per_diff, per_abs;
    logic [12:0] hi_rnd, hi_shift;
    logic [7:0]  duty_calc;
    logic        per_ok, enter_to;

    assign per_diff  = $signed({1'b0, per_cnt}) - PER13;
    assign per_abs   = per_diff[12] ? -per_diff : per_diff;
    assign per_ok    = (per_abs <= TOL13);
    assign hi_rnd    = {1'b0, hi_cnt} + 13'd2;
    assign hi_shift  = hi_rnd >> 2;
    assign duty_calc = (hi_shift > 13'd255) ? 8'hFF : hi_shift[7:0];
    // Any edge on the threshold cycle pre-empts the timeout.
    assign enter_to  = (state != TIMEOUT) && !rise && !fall && (idle_cnt >= TO12);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            hi_cnt   <= '0;
            per_cnt  <= '0;
            idle_cnt <= '0;
            duty_r   <= '0;
            valid_r  <= 1'b0;
            perr_r   <= 1'b0;
            high_r   <= '0;
        end else begin
            valid_r <= 1'b0;
            if (rise || fall)
                idle_cnt <= '0;
            else if (tick && idle_cnt != CNT_MAX)
                idle_cnt <= idle_cnt + 12'd1;

            if (enter_to) begin
                state   <= TIMEOUT;
                duty_r  <= level ? 8'hFF : 8'h00;
                perr_r  <= 1'b0;
                high_r  <= '0;
                valid_r <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state   <= MEAS;
                            hi_cnt  <= '0;
                            per_cnt <= '0;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            high_r  <= hi_cnt;
                            valid_r <= 1'b1;
                            if (per_ok) begin
                                duty_r <= duty_calc;
                                perr_r <= 1'b0;
                            end else begin
                                perr_r <= 1'b1;
                            end
                            hi_cnt  <= '0;
                            per_cnt <= '0;
                        end else if (tick) begin
                            if (per_cnt != CNT_MAX)
                                per_cnt <= per_cnt + 12'd1;
                            if (level && hi_cnt != CNT_MAX)
                                hi_cnt <= hi_cnt + 12'd1;
                        end
                    end
                    TIMEOUT: begin
                        if (rise) begin
                            state   <= MEAS;
                            hi_cnt  <= '0;
                            per_cnt <= '0;
                        end else if (fall) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign cap.duty      = duty_r;
    assign cap.dutyValid = valid_r;
    assign cap.periodErr = perr_r;
    assign cap.highTicks = high_r;
endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized scoreboard bench for pwm_capture
module tb_pwm_capture;
    localparam int PS  = 2;
    localparam int PT  = 1024;
    localparam int TOL = 8;
    localparam int TO  = 2048;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pwm   = 1'b0;

    pwm_capture_if bus ();

    pwm_capture #(
        .PRESCALE(PS), .PERIOD_TICKS(PT), .TOL_TICKS(TOL), .TIMEOUT_TICKS(TO)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .pwmIn(pwm), .cap(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int perr;
        int hlo;
        int hhi;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   last_duty = 0;
    bit   armed = 0;
    int   cur_h = 0;
    int   cur_p = 0;
    bit   cur_tail = 0;
    int   ptab[6] = '{1024, 1017, 1032, 1015, 1034, 1040};

    task automatic check(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // The measured period is P or P-1 ticks depending on prescaler phase; both must agree.
    function automatic bit period_ok(input int p);
        int a;
        a = p - PT;
        return (a <= TOL) && (a >= -TOL) && (a - 1 <= TOL) && (a - 1 >= -TOL);
    endfunction

    task automatic push_frame();
        exp_t e;
        int   d;
        if (cur_tail) begin
            e.duty = last_duty; e.perr = 1; e.hlo = 0; e.hhi = 1;
        end else begin
            d = (cur_h + 2) / 4;
            if (d > 255) d = 255;
            if (period_ok(cur_p)) last_duty = d;
            e.duty = last_duty;
            e.perr = period_ok(cur_p) ? 0 : 1;
            e.hlo  = cur_h - 1;
            e.hhi  = cur_h;
        end
        q.push_back(e);
    endtask

    task automatic rise();
        if (armed) push_frame();
        armed = 1;
        pwm = 1'b1;
    endtask

    task automatic send_frame(input int h, input int p);
        rise();
        cur_h = h; cur_p = p; cur_tail = 0;
        repeat (h * PS) @(negedge clk);
        pwm = 1'b0;
        repeat ((p - h) * PS) @(negedge clk);
    endtask

    task automatic glitch_frame(input int h, input int p, input int g);
        rise();
        cur_h = h; cur_p = p; cur_tail = 0;
        repeat (h * PS) @(negedge clk);
        pwm = 1'b0;
        repeat (g * PS) @(negedge clk);
`ifndef PWM_CAPTURE_FILTER_EN
        cur_p = h + g;
        push_frame();
        cur_tail = 1;
`endif
        pwm = 1'b1;
        repeat (2) @(negedge clk);
        pwm = 1'b0;
        repeat ((p - h - g) * PS - 2) @(negedge clk);
    endtask

    task automatic hold_timeout(input bit lvl);
        exp_t e;
        if (lvl && !pwm) rise();
        else if (!lvl) pwm = 1'b0;
        e.duty = lvl ? 255 : 0; e.perr = 0; e.hlo = 0; e.hhi = 0;
        q.push_back(e);
        last_duty = e.duty;
        armed = 0;
        repeat ((TO + 60) * PS) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_duty"}, int'(bus.duty), 0, 0);
        check({tag, "_valid"}, int'(bus.dutyValid), 0, 0);
        check({tag, "_perr"}, int'(bus.periodErr), 0, 0);
        check({tag, "_high"}, int'(bus.highTicks), 0, 0);
    endtask

    initial begin : monitor
        bit prev_dv;
        prev_dv = 0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.dutyValid) begin
                check("no_back_to_back", int'(prev_dv), 0, 0);
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got duty=%0d perr=%0d, expected no pulse",
                             bus.duty, bus.periodErr);
                end else begin
                    mon_e = q.pop_front();
                    check("duty", int'(bus.duty), mon_e.duty, mon_e.duty);
                    check("periodErr", int'(bus.periodErr), mon_e.perr, mon_e.perr);
                    check("highTicks", int'(bus.highTicks), mon_e.hlo, mon_e.hhi);
                end
            end
            prev_dv = rst_n && bus.dutyValid;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no end of stimulus, expected finish within 90000 cycles");
        $fatal(1);
    end

    initial begin : stimulus
        int h;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        send_frame(512, 1024);
        send_frame(512, 1024);
        send_frame(4, 1024);
        send_frame(256, 1024);
        send_frame(800, 1024);
        send_frame(1020, 1024);
        send_frame(1022, 1024);
        send_frame(400, 1040);
        send_frame(400, 1024);
        for (int i = 0; i < 4; i++) begin
            h = 4 * int'($urandom_range(1, 255));
            send_frame(h, ptab[i + 1]);
        end
        for (int i = 0; i < 4; i++) begin
            h = 4 * int'($urandom_range(1, 255));
            send_frame(h, ptab[$urandom_range(0, 5)]);
        end
        send_frame(400, 1024);
        glitch_frame(400, 1024, 100);
        send_frame(600, 1024);

        hold_timeout(1'b0);
        hold_timeout(1'b1);
        pwm = 1'b0;
        repeat (50 * PS) @(negedge clk);
        send_frame(200, 1024);
        send_frame(300, 1024);

        check("pre_reset_duty_nonzero", int'(bus.duty != 8'd0), 1, 1);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        armed = 0;
        last_duty = 0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(240, 1024);
        send_frame(480, 1024);
        rise();
        repeat (40) @(negedge clk);

        check("queue_drained", q.size(), 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
